alu_issue_queue: RTL and testbench

- Out-of-order ALU issue queue that sits directly upstream of the fast register file.
- Accepts up to 2 renamed ALU ops per cycle from dispatch and holds them until both source physical registers are ready.
- Wakes sources on the 4 writeback ports and issues up to 2 ready ops per cycle, oldest first, into the register-file read stage.
- Squashes entries on a branch recall.

---
 rtl/alu_issue_queue.sv | 258 +++++++++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Collapsing out-of-order ALU issue queue: 2-wide dispatch, 4-port wakeup,
// 2-wide oldest-first select with registered issue outputs and branch-recall squash.
module alu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PR_W  = 6,
  parameter int AL_W  = 5,
  parameter int PL_W  = 96,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ext_stall,
  input  logic                      if_recall,
  input  logic [AL_W-1:0]           new_front,
  input  logic [AL_W-1:0]           old_front,
  input  logic [1:0]                disp_valid,
  input  logic [1:0][PR_W-1:0]      disp_rs1,
  input  logic [1:0][PR_W-1:0]      disp_rs2,
  input  logic [1:0]                disp_rs1_rdy,
  input  logic [1:0]                disp_rs2_rdy,
  input  logic [1:0][PR_W-1:0]      disp_rd,
  input  logic [1:0]                disp_uses_rd,
  input  logic [1:0][AL_W-1:0]      disp_al_addr,
  input  logic [1:0][PL_W-1:0]      disp_payload,
  output logic                      disp_ready,
  input  logic [3:0]                wb_valid,
  input  logic [3:0]                wb_uses_rd,
  input  logic [3:0][PR_W-1:0]      wb_rd,
  output logic [1:0]                iss_valid,
  output logic [1:0][PR_W-1:0]      iss_rs1,
  output logic [1:0][PR_W-1:0]      iss_rs2,
  output logic [1:0][PR_W-1:0]      iss_rd,
  output logic [1:0]                iss_uses_rd,
  output logic [1:0][AL_W-1:0]      iss_al_addr,
  output logic [1:0][PL_W-1:0]      iss_payload,
  output logic [CW-1:0]             count
);

  localparam int IW = $clog2(DEPTH);

  // Circular membership in [nf, of), computed modulo 2^AL_W.
  function automatic logic in_range(input logic [AL_W-1:0] a,
                                    input logic [AL_W-1:0] nf,
                                    input logic [AL_W-1:0] of);
    logic [AL_W-1:0] d_a;
    logic [AL_W-1:0] d_w;
    d_a = a - nf;
    d_w = of - nf;
    return d_a < d_w;
  endfunction

  function automatic logic tag_hit(input logic [PR_W-1:0] tag,
                                   input logic [3:0] live,
                                   input logic [3:0][PR_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < 4; p++)
      if (live[p] && tags[p] == tag) hit = 1'b1;
    return hit;
  endfunction

  logic [DEPTH-1:0] valid_reg, rdy1_reg, rdy2_reg, uses_reg;
  logic [DEPTH-1:0] valid_next, rdy1_next, rdy2_next, uses_next;
  logic [PR_W-1:0]  rs1_reg [DEPTH];
  logic [PR_W-1:0]  rs2_reg [DEPTH];
  logic [PR_W-1:0]  rd_reg  [DEPTH];
  logic [AL_W-1:0]  al_reg  [DEPTH];
  logic [PL_W-1:0]  pl_reg  [DEPTH];
  logic [PR_W-1:0]  rs1_next [DEPTH];
  logic [PR_W-1:0]  rs2_next [DEPTH];
  logic [PR_W-1:0]  rd_next  [DEPTH];
  logic [AL_W-1:0]  al_next  [DEPTH];
  logic [PL_W-1:0]  pl_next  [DEPTH];

  logic [CW-1:0] count_reg, count_next;
  logic          disp_ready_reg, disp_ready_next;

  logic [1:0]             iss_valid_reg, iss_valid_next;
  logic [1:0][PR_W-1:0]   iss_rs1_reg, iss_rs1_next, iss_rs2_reg, iss_rs2_next;
  logic [1:0][PR_W-1:0]   iss_rd_reg, iss_rd_next;
  logic [1:0]             iss_uses_reg, iss_uses_next;
  logic [1:0][AL_W-1:0]   iss_al_reg, iss_al_next;
  logic [1:0][PL_W-1:0]   iss_pl_reg, iss_pl_next;

  logic [3:0]       wb_live;
  logic [DEPTH-1:0] wake1, wake2, ready, squash, sel_mask, keep;
  logic [1:0]       disp_w1, disp_w2, disp_acc;
  logic [1:0]       sel_found;
  logic [IW-1:0]    sel_idx [2];

  assign wb_live = wb_valid & wb_uses_rd;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wake1[gi]  = rdy1_reg[gi] | tag_hit(rs1_reg[gi], wb_live, wb_rd);
      assign wake2[gi]  = rdy2_reg[gi] | tag_hit(rs2_reg[gi], wb_live, wb_rd);
      assign ready[gi]  = valid_reg[gi] & rdy1_reg[gi] & rdy2_reg[gi];
      assign squash[gi] = valid_reg[gi] & if_recall & in_range(al_reg[gi], new_front, old_front);
    end
    for (gi = 0; gi < 2; gi++) begin : g_disp
      assign disp_w1[gi]  = disp_rs1_rdy[gi] | tag_hit(disp_rs1[gi], wb_live, wb_rd);
      assign disp_w2[gi]  = disp_rs2_rdy[gi] | tag_hit(disp_rs2[gi], wb_live, wb_rd);
      assign disp_acc[gi] = disp_valid[gi] & disp_ready_reg &
                            ~(if_recall & in_range(disp_al_addr[gi], new_front, old_front));
    end
  endgenerate

  // Oldest-first select of up to two entries, using only the stored ready bits.
  always_comb begin
    sel_found = '0;
    sel_idx[0] = '0;
    sel_idx[1] = '0;
    sel_mask = '0;
    if (!ext_stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ready[i]) begin
          if (!sel_found[0]) begin
            sel_found[0] = 1'b1;
            sel_idx[0]   = IW'(i);
            sel_mask[i]  = 1'b1;
          end else if (!sel_found[1]) begin
            sel_found[1] = 1'b1;
            sel_idx[1]   = IW'(i);
            sel_mask[i]  = 1'b1;
          end
        end
      end
    end
  end

  assign keep = valid_reg & ~sel_mask & ~squash;

  // Compact survivors toward index 0, then append accepted dispatches.
  always_comb begin
    logic [CW-1:0] pos;
    logic [IW-1:0] idx;
    valid_next = '0;
    rdy1_next  = '0;
    rdy2_next  = '0;
    uses_next  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_next[i] = rs1_reg[i];
      rs2_next[i] = rs2_reg[i];
      rd_next[i]  = rd_reg[i];
      al_next[i]  = al_reg[i];
      pl_next[i]  = pl_reg[i];
    end
    pos = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        idx = pos[IW-1:0];
        valid_next[idx] = 1'b1;
        rdy1_next[idx]  = wake1[i];
        rdy2_next[idx]  = wake2[i];
        uses_next[idx]  = uses_reg[i];
        rs1_next[idx]   = rs1_reg[i];
        rs2_next[idx]   = rs2_reg[i];
        rd_next[idx]    = rd_reg[i];
        al_next[idx]    = al_reg[i];
        pl_next[idx]    = pl_reg[i];
        pos = pos + 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (disp_acc[k] && pos < CW'(DEPTH)) begin
        idx = pos[IW-1:0];
        valid_next[idx] = 1'b1;
        rdy1_next[idx]  = disp_w1[k];
        rdy2_next[idx]  = disp_w2[k];
        uses_next[idx]  = disp_uses_rd[k];
        rs1_next[idx]   = disp_rs1[k];
        rs2_next[idx]   = disp_rs2[k];
        rd_next[idx]    = disp_rd[k];
        al_next[idx]    = disp_al_addr[k];
        pl_next[idx]    = disp_payload[k];
        pos = pos + 1'b1;
      end
    end
    count_next      = pos;
    disp_ready_next = (pos <= CW'(DEPTH - 2));
  end

  // Issue registers: load the new selection, or hold under stall while still honouring recall.
  always_comb begin
    iss_valid_next = iss_valid_reg;
    iss_rs1_next   = iss_rs1_reg;
    iss_rs2_next   = iss_rs2_reg;
    iss_rd_next    = iss_rd_reg;
    iss_uses_next  = iss_uses_reg;
    iss_al_next    = iss_al_reg;
    iss_pl_next    = iss_pl_reg;
    for (int k = 0; k < 2; k++) begin
      if (!ext_stall) begin
        iss_valid_next[k] = sel_found[k] & ~squash[sel_idx[k]];
        iss_rs1_next[k]   = rs1_reg[sel_idx[k]];
        iss_rs2_next[k]   = rs2_reg[sel_idx[k]];
        iss_rd_next[k]    = rd_reg[sel_idx[k]];
        iss_uses_next[k]  = uses_reg[sel_idx[k]];
        iss_al_next[k]    = al_reg[sel_idx[k]];
        iss_pl_next[k]    = pl_reg[sel_idx[k]];
      end else if (if_recall && in_range(iss_al_reg[k], new_front, old_front)) begin
        iss_valid_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg      <= '0;
      rdy1_reg       <= '0;
      rdy2_reg       <= '0;
      uses_reg       <= '0;
      count_reg      <= '0;
      disp_ready_reg <= 1'b1;
      iss_valid_reg  <= '0;
      iss_rs1_reg    <= '0;
      iss_rs2_reg    <= '0;
      iss_rd_reg     <= '0;
      iss_uses_reg   <= '0;
      iss_al_reg     <= '0;
      iss_pl_reg     <= '0;
    end else begin
      valid_reg      <= valid_next;
      rdy1_reg       <= rdy1_next;
      rdy2_reg       <= rdy2_next;
      uses_reg       <= uses_next;
      count_reg      <= count_next;
      disp_ready_reg <= disp_ready_next;
      iss_valid_reg  <= iss_valid_next;
      iss_rs1_reg    <= iss_rs1_next;
      iss_rs2_reg    <= iss_rs2_next;
      iss_rd_reg     <= iss_rd_next;
      iss_uses_reg   <= iss_uses_next;
      iss_al_reg     <= iss_al_next;
      iss_pl_reg     <= iss_pl_next;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_reg[i] <= rs1_next[i];
        rs2_reg[i] <= rs2_next[i];
        rd_reg[i]  <= rd_next[i];
        al_reg[i]  <= al_next[i];
        pl_reg[i]  <= pl_next[i];
      end
    end
  end

  assign disp_ready  = disp_ready_reg;
  assign count       = count_reg;
  assign iss_valid   = iss_valid_reg;
  assign iss_rs1     = iss_rs1_reg;
  assign iss_rs2     = iss_rs2_reg;
  assign iss_rd      = iss_rd_reg;
  assign iss_uses_rd = iss_uses_reg;
  assign iss_al_addr = iss_al_reg;
  assign iss_payload = iss_pl_reg;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue against an age-ordered queue model,
// with directed scenarios for latency, full, wrap-around recall, stall and reset.
module tb_alu_issue_queue;

  logic clk = 1'b0;
  logic reset, ext_stall, if_recall;
  logic [4:0] new_front, old_front;
  logic [1:0] disp_valid, disp_rs1_rdy, disp_rs2_rdy, disp_uses_rd;
  logic [1:0][5:0] disp_rs1, disp_rs2, disp_rd;
  logic [1:0][4:0] disp_al_addr;
  logic [1:0][95:0] disp_payload;
  logic disp_ready;
  logic [3:0] wb_valid, wb_uses_rd;
  logic [3:0][5:0] wb_rd;
  logic [1:0] iss_valid, iss_uses_rd;
  logic [1:0][5:0] iss_rs1, iss_rs2, iss_rd;
  logic [1:0][4:0] iss_al_addr;
  logic [1:0][95:0] iss_payload;
  logic [3:0] count;

  alu_issue_queue dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .if_recall(if_recall),
    .new_front(new_front), .old_front(old_front),
    .disp_valid(disp_valid), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy), .disp_rd(disp_rd),
    .disp_uses_rd(disp_uses_rd), .disp_al_addr(disp_al_addr), .disp_payload(disp_payload),
    .disp_ready(disp_ready), .wb_valid(wb_valid), .wb_uses_rd(wb_uses_rd), .wb_rd(wb_rd),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_uses_rd(iss_uses_rd), .iss_al_addr(iss_al_addr), .iss_payload(iss_payload),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] rs1, rs2, rd;
    bit r1, r2, u;
    logic [4:0] al;
    logic [95:0] pl;
  } op_t;

  op_t q[$];
  op_t e_is[2];
  bit [1:0] e_iv;
  int e_cnt;
  bit e_rdy;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit inr(input logic [4:0] a);
    return ((int'(a) - int'(new_front) + 32) % 32) < ((int'(old_front) - int'(new_front) + 32) % 32);
  endfunction

  function automatic bit woke(input logic [5:0] tag);
    for (int p = 0; p < 4; p++)
      if (wb_valid[p] && wb_uses_rd[p] && wb_rd[p] == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: one clock of queue behaviour from the current inputs.
  task automatic model_step();
    op_t nq[$];
    int sel[$];
    op_t o;
    if (reset) begin
      q.delete(); e_iv = 0; e_cnt = 0; e_rdy = 1; return;
    end
    if (!ext_stall)
      foreach (q[i]) if (q[i].r1 && q[i].r2 && sel.size() < 2) sel.push_back(i);
    if (!ext_stall) begin
      e_iv = 0;
      foreach (sel[k]) begin
        e_is[k] = q[sel[k]];
        e_iv[k] = !(if_recall && inr(q[sel[k]].al));
      end
    end else begin
      for (int k = 0; k < 2; k++) if (if_recall && inr(e_is[k].al)) e_iv[k] = 0;
    end
    foreach (q[i]) begin
      bit picked = 0;
      foreach (sel[k]) if (sel[k] == i) picked = 1;
      if (!picked && !(if_recall && inr(q[i].al))) begin
        o = q[i];
        o.r1 = o.r1 | woke(o.rs1);
        o.r2 = o.r2 | woke(o.rs2);
        nq.push_back(o);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (disp_valid[k] && e_rdy && !(if_recall && inr(disp_al_addr[k]))) begin
        o.rs1 = disp_rs1[k]; o.rs2 = disp_rs2[k]; o.rd = disp_rd[k];
        o.r1 = disp_rs1_rdy[k] | woke(disp_rs1[k]);
        o.r2 = disp_rs2_rdy[k] | woke(disp_rs2[k]);
        o.u = disp_uses_rd[k]; o.al = disp_al_addr[k]; o.pl = disp_payload[k];
        nq.push_back(o);
      end
    end
    q = nq;
    e_cnt = q.size();
    e_rdy = (e_cnt <= 6);
  endtask

  task automatic compare();
    chk("iss_valid", iss_valid, e_iv);
    for (int k = 0; k < 2; k++) begin
      if (e_iv[k]) begin
        chk($sformatf("iss%0d_rs1", k), iss_rs1[k], e_is[k].rs1);
        chk($sformatf("iss%0d_rs2", k), iss_rs2[k], e_is[k].rs2);
        chk($sformatf("iss%0d_rd", k), iss_rd[k], e_is[k].rd);
        chk($sformatf("iss%0d_uses", k), iss_uses_rd[k], e_is[k].u);
        chk($sformatf("iss%0d_al", k), iss_al_addr[k], e_is[k].al);
        chk($sformatf("iss%0d_pl", k), iss_payload[k], e_is[k].pl);
      end
    end
    chk("count", count, e_cnt);
    chk("count_le_depth", count <= 4'd8, 1'b1);
    chk("disp_ready", disp_ready, e_rdy);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clr();
    reset = 0; ext_stall = 0; if_recall = 0; new_front = 0; old_front = 0;
    disp_valid = 0; disp_rs1 = 0; disp_rs2 = 0; disp_rs1_rdy = 0; disp_rs2_rdy = 0;
    disp_rd = 0; disp_uses_rd = 0; disp_al_addr = 0; disp_payload = 0;
    wb_valid = 0; wb_uses_rd = 0; wb_rd = 0;
  endtask

  task automatic disp(input int k, input int rs1, input bit r1, input int rs2, input bit r2, input int al);
    disp_valid[k] = 1; disp_rs1[k] = 6'(rs1); disp_rs1_rdy[k] = r1;
    disp_rs2[k] = 6'(rs2); disp_rs2_rdy[k] = r2; disp_rd[k] = 6'($urandom);
    disp_uses_rd[k] = 1'($urandom); disp_al_addr[k] = 5'(al);
    disp_payload[k] = {$urandom, $urandom, $urandom};
  endtask

  task automatic wb(input int p, input int tag);
    wb_valid[p] = 1; wb_uses_rd[p] = 1; wb_rd[p] = 6'(tag);
  endtask

  task automatic do_reset();
    clr(); reset = 1; step(); step(); reset = 0;
  endtask

  initial begin
    clr();
    e_iv = 0; e_cnt = 0; e_rdy = 1;
    do_reset();
    chk("rst_iss_valid", iss_valid, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_disp_ready", disp_ready, 1'b1);

    // Two ready ops issue together two cycles after dispatch.
    clr(); disp(0, 1, 1, 2, 1, 4); disp(1, 3, 1, 4, 1, 5); step();
    clr(); step();
    chk("t1_iss_valid", iss_valid, 2'b11);
    chk("t1_age_order", {iss_al_addr[1], iss_al_addr[0]}, {5'd5, 5'd4});
    step();
    chk("t1_count", count, 0);

    // Wakeup after residency, then wakeup in the dispatch cycle.
    clr(); disp(0, 17, 0, 9, 1, 6); step();
    clr(); step();
    clr(); wb(2, 17); step();
    chk("t2_not_early", iss_valid, 2'b00);
    clr(); step();
    chk("t2_woken_issue", iss_valid, 2'b01);
    clr(); disp(0, 17, 0, 9, 1, 7); wb(2, 17); step();
    clr(); step();
    chk("t2_same_cycle_wake", iss_valid, 2'b01);

    // Fill with not-ready ops, then wake entries 0 and 3.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clr(); disp(0, 32 + 2 * c, 0, 1, 1, 2 * c); disp(1, 33 + 2 * c, 0, 1, 1, 2 * c + 1); step();
    end
    chk("t3_full_not_ready", disp_ready, 1'b0);
    clr(); wb(0, 32); wb(3, 35); step();
    clr(); step();
    chk("t3_pair_issue", iss_valid, 2'b11);
    chk("t3_pair_tags", {iss_rs1[1], iss_rs1[0]}, {6'd35, 6'd32});
    chk("t3_ready_again", disp_ready, 1'b1);

    // Wrap-around recall over al 28..31,0..3.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clr(); disp(0, 40, 0, 1, 1, (28 + 2 * c) % 32); disp(1, 40, 0, 1, 1, (29 + 2 * c) % 32); step();
    end
    clr(); if_recall = 1; new_front = 30; old_front = 2; step();
    chk("t4_count", count, 4);
    clr(); wb(1, 40); step();
    clr(); step();
    chk("t4_first_survivors", {iss_al_addr[1], iss_al_addr[0]}, {5'd29, 5'd28});
    step();
    chk("t4_next_survivors", {iss_al_addr[1], iss_al_addr[0]}, {5'd3, 5'd2});

    // Stall holds issue registers for three cycles.
    do_reset();
    clr(); disp(0, 1, 1, 1, 1, 10); disp(1, 1, 1, 1, 1, 11); step();
    clr(); disp(0, 1, 1, 1, 1, 12); disp(1, 1, 1, 1, 1, 13); step();
    for (int c = 0; c < 3; c++) begin
      clr(); ext_stall = 1; step();
    end
    chk("t5_held", {iss_al_addr[1], iss_al_addr[0]}, {5'd11, 5'd10});
    chk("t5_kept", count, 2);
    clr(); step();
    chk("t5_resume", {iss_al_addr[1], iss_al_addr[0]}, {5'd13, 5'd12});

    // Reset wins over recall and dispatch.
    do_reset();
    clr(); disp(0, 1, 1, 1, 1, 3); disp(1, 1, 0, 1, 1, 4); step();
    clr(); reset = 1; if_recall = 1; new_front = 0; old_front = 8;
    disp(0, 1, 1, 1, 1, 20); disp(1, 1, 1, 1, 1, 21); step();
    chk("t6_iss_valid", iss_valid, 2'b00);
    chk("t6_count", count, 0);
    chk("t6_disp_ready", disp_ready, 1'b1);

    // Randomized traffic.
    clr();
    for (int c = 0; c < 3000; c++) begin
      clr();
      reset = ($urandom % 200) == 0;
      ext_stall = ($urandom % 5) == 0;
      if (($urandom % 12) == 0) begin
        if_recall = 1;
        new_front = 5'($urandom);
        old_front = new_front + 5'($urandom % 8);
      end
      if (e_rdy && ($urandom % 3) != 0) begin
        for (int k = 0; k < 2; k++)
          disp(k, $urandom % 16, 1'($urandom), $urandom % 16, 1'($urandom), $urandom % 32);
        disp_valid = 2'($urandom);
      end
      for (int p = 0; p < 4; p++) begin
        wb_valid[p] = ($urandom % 5) < 2;
        wb_uses_rd[p] = ($urandom % 4) != 0;
        wb_rd[p] = 6'($urandom % 16);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
